// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the requesters and the ALU arbiter.
// Valid/ready semantics on both channels: a transfer happens on a rising
// clock edge where valid and ready are both high. A requester holds valid
// and its payload stable until it sees ready. It may drop valid before a
// grant with no side effect. The arbiter holds rsp_* stable while
// rsp_valid is high and rsp_ready is low.
interface alu_arbiter_if #(
   parameter int NUM_REQ = 4
);
   localparam int ID_W = $clog2(NUM_REQ);

   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [8*NUM_REQ-1:0] req_a;
   logic [8*NUM_REQ-1:0] req_b;
   logic [3*NUM_REQ-1:0] req_op;
   logic [NUM_REQ-1:0]   req_lock;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [ID_W-1:0]      rsp_id;
   logic [7:0]           rsp_result;
   logic                 rsp_zero;

   // Requester / response-consumer side.
   modport master (
      output req_valid, req_a, req_b, req_op, req_lock, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
   );

   // Arbiter side.
   modport slave (
      input  req_valid, req_a, req_b, req_op, req_lock, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter and sequencer that shares one combinational 8-bit ALU
// among NUM_REQ requesters. It serves one operation at a time in three
// phases: IDLE (arbitrate and latch), EXEC (ALU driven from registers,
// result captured) and RESP (response held until consumed).
// Optional feature macro ARB_LOCK_EN: a request accepted with req_lock set
// keeps the round-robin pointer on its requester after release. Without the
// macro, req_lock is ignored and strict round-robin applies.
module alu_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = $clog2(NUM_REQ)
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_arbiter_if.slave bus,
   output logic [7:0]   alu_a,
   output logic [7:0]   alu_b,
   output logic [2:0]   alu_op,
   input  logic [7:0]   alu_result,
   input  logic         alu_zero,
   output logic [1:0]   dbg_state
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_EXEC = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
   logic [ID_W-1:0]     grant_q, grant_d;
   logic [7:0]          a_q, a_d;
   logic [7:0]          b_q, b_d;
   logic [2:0]          op_q, op_d;
   logic [7:0]          result_q, result_d;
   logic                zero_q, zero_d;
`ifdef ARB_LOCK_EN
   logic                lock_q, lock_d;
`endif

   logic                grant_found;
   logic [ID_W-1:0]     grant_idx;
   logic [ID_W-1:0]     scan_idx;
   logic [ID_W-1:0]     grant_next;
   logic [NUM_REQ-1:0]  ready_c;
   int                  scan_pos;

`ifndef ARB_LOCK_EN
   // The lock input is part of the port list but carries no meaning here.
   logic unused_lock;
   assign unused_lock = ^bus.req_lock;
`endif

   // Find the first valid requester at or above rr_ptr, wrapping at NUM_REQ-1.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_pos    = 0;
      scan_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_pos = (int'(rr_ptr_q) + k) % NUM_REQ;
         scan_idx = ID_W'(scan_pos);
         if (!grant_found && bus.req_valid[scan_idx]) begin
            grant_found = 1'b1;
            grant_idx   = scan_idx;
         end
      end
   end

   // Next-state logic, operand/response latching and the one-cycle accept strobe.
   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      grant_d    = grant_q;
      a_d        = a_q;
      b_d        = b_q;
      op_d       = op_q;
      result_d   = result_q;
      zero_d     = zero_q;
`ifdef ARB_LOCK_EN
      lock_d     = lock_q;
`endif
      ready_c    = '0;
      grant_next = (grant_q == ID_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
      case (state_q)
         ST_IDLE: begin
            if (grant_found) begin
               ready_c[grant_idx] = 1'b1;
               grant_d = grant_idx;
               a_d     = bus.req_a[int'(grant_idx) * 8 +: 8];
               b_d     = bus.req_b[int'(grant_idx) * 8 +: 8];
               op_d    = bus.req_op[int'(grant_idx) * 3 +: 3];
`ifdef ARB_LOCK_EN
               lock_d  = bus.req_lock[grant_idx];
`endif
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: begin
            // The ALU sees only the registered operands during this cycle.
            result_d = alu_result;
            zero_d   = alu_zero;
            state_d  = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
`ifdef ARB_LOCK_EN
               rr_ptr_d = lock_q ? grant_q : grant_next;
`else
               rr_ptr_d = grant_next;
`endif
               state_d  = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         a_q      <= '0;
         b_q      <= '0;
         op_q     <= '0;
         result_q <= '0;
         zero_q   <= 1'b0;
`ifdef ARB_LOCK_EN
         lock_q   <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         a_q      <= a_d;
         b_q      <= b_d;
         op_q     <= op_d;
         result_q <= result_d;
         zero_q   <= zero_d;
`ifdef ARB_LOCK_EN
         lock_q   <= lock_d;
`endif
      end
   end

   // The accept strobe is gated by reset so that no grant shows while rst_n is low.
   assign bus.req_ready  = rst_n ? ready_c : '0;
   assign bus.rsp_valid  = (state_q == ST_RESP);
   assign bus.rsp_id     = grant_q;
   assign bus.rsp_result = result_q;
   assign bus.rsp_zero   = zero_q;
   assign alu_a          = a_q;
   assign alu_b          = b_q;
   assign alu_op         = op_q;
   assign dbg_state      = state_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: stand-in ALU, requester drivers, and a
// transaction-level reference (round-robin pick, ALU arithmetic, expected
// response queue). It also runs directed scenarios and a final report.
module tb_alu_arbiter;
   localparam int N  = 4;
   localparam int IW = 2;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [7:0] alu_a, alu_b, alu_result;
   logic [2:0] alu_op;
   logic       alu_zero;
   logic [1:0] dbg_state;

   alu_arbiter_if #(.NUM_REQ(N)) bus ();

   alu_arbiter #(.NUM_REQ(N)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .bus        (bus),
      .alu_a      (alu_a),
      .alu_b      (alu_b),
      .alu_op     (alu_op),
      .alu_result (alu_result),
      .alu_zero   (alu_zero),
      .dbg_state  (dbg_state)
   );

   // clock
   always #5 clk = ~clk;

   function automatic logic [7:0] alu_fn(logic [7:0] a, logic [7:0] b, logic [2:0] op);
      case (op)
         3'd0:    return a & b;
         3'd1:    return a + b;
         3'd2:    return a - b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return ~a;
         3'd6:    return {a[6:0], 1'b0};
         default: return {1'b0, a[7:1]};
      endcase
   endfunction

   // stand-in ALU
   always_comb begin
      alu_result = alu_fn(alu_a, alu_b, alu_op);
      alu_zero   = (alu_result == 8'h00);
   end

   function automatic int rr_pick(logic [N-1:0] v, int ptr);
      for (int k = 0; k < N; k++) begin
         if (v[(ptr + k) % N]) return (ptr + k) % N;
      end
      return -1;
   endfunction

   // stimulus state
   logic [N-1:0] pend = '0;
   logic [N-1:0] rlock = '0;
   logic [7:0]   ra [N];
   logic [7:0]   rb [N];
   logic [2:0]   rop [N];
   logic         rsp_rdy = 1'b1;
   logic         rst_drv = 1'b0;
   logic         keep_all = 1'b0;

   // reference model / scoreboard state
   logic [IW+8:0] exp_q[$];
   bit            m_busy = 0;
   int            m_ptr = 0;
   int            m_acc = 0;
   int            m_g = 0;
   logic [7:0]    m_a, m_b;
   logic [2:0]    m_op;
   logic          m_lock;

   // observation
   int         grant_log[$];
   int         grant_cyc[$];
   int         rv_cnt = 0;
   int         n_rsp = 0;
   int         cyc = 0;
   logic [7:0] last_res = '0;
   logic       last_zero = 1'b0;
   logic [IW-1:0] last_id = '0;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic new_op(int i);
      ra[i]   = 8'($urandom_range(0, 255));
      rb[i]   = 8'($urandom_range(0, 255));
      rop[i]  = 3'($urandom_range(0, 7));
      pend[i] = 1'b1;
   endtask

   task automatic set_req(int i, logic [7:0] a, logic [7:0] b, logic [2:0] op);
      ra[i]   = a;
      rb[i]   = b;
      rop[i]  = op;
      pend[i] = 1'b1;
   endtask

   // one clock cycle: drive at negedge, check against model, react to grants
   task automatic step();
      logic [N-1:0]  exp_ready;
      logic [IW+8:0] e;
      logic [7:0]    er;
      int            g;
      bit            exp_rv;
      @(negedge clk);
      rst_n         = rst_drv;
      bus.req_valid = pend;
      bus.req_lock  = rlock;
      bus.rsp_ready = rsp_rdy;
      for (int i = 0; i < N; i++) begin
         bus.req_a[8*i +: 8]  = ra[i];
         bus.req_b[8*i +: 8]  = rb[i];
         bus.req_op[3*i +: 3] = rop[i];
      end
      #1;
      if (!rst_n) begin
         check("rst_req_ready", bus.req_ready, 0);
         check("rst_rsp_valid", bus.rsp_valid, 0);
         check("rst_rsp_id", bus.rsp_id, 0);
         check("rst_rsp_result", bus.rsp_result, 0);
         check("rst_rsp_zero", bus.rsp_zero, 0);
         check("rst_alu_a", alu_a, 0);
         check("rst_alu_b", alu_b, 0);
         check("rst_alu_op", alu_op, 0);
         m_busy = 0;
         m_ptr  = 0;
         exp_q.delete();
      end else begin
         exp_ready = '0;
         g = -1;
         if (!m_busy) begin
            g = rr_pick(pend, m_ptr);
            if (g >= 0) exp_ready[g] = 1'b1;
         end
         check("req_ready", bus.req_ready, exp_ready);
         if (m_busy && (cyc - m_acc) == 1) begin
            check("exec_alu_a", alu_a, m_a);
            check("exec_alu_b", alu_b, m_b);
            check("exec_alu_op", alu_op, m_op);
         end
         exp_rv = m_busy && (cyc - m_acc) >= 2;
         check("rsp_valid", bus.rsp_valid, exp_rv);
         if (exp_rv) begin
            e = exp_q[0];
            check("rsp_id", bus.rsp_id, e[IW+8:9]);
            check("rsp_result", bus.rsp_result, e[8:1]);
            check("rsp_zero", bus.rsp_zero, e[0]);
            check("resp_alu_a_hold", alu_a, m_a);
            check("resp_alu_op_hold", alu_op, m_op);
            if (rsp_rdy) begin
               void'(exp_q.pop_front());
               m_busy = 0;
               n_rsp++;
`ifdef ARB_LOCK_EN
               m_ptr = m_lock ? m_g : (m_g + 1) % N;
`else
               m_ptr = (m_g + 1) % N;
`endif
            end
         end
         if (g >= 0) begin
            m_busy = 1;
            m_acc  = cyc;
            m_g    = g;
            m_a    = ra[g];
            m_b    = rb[g];
            m_op   = rop[g];
            m_lock = rlock[g];
            er     = alu_fn(ra[g], rb[g], rop[g]);
            exp_q.push_back({IW'(g), er, (er == 8'h00)});
            grant_log.push_back(g);
            grant_cyc.push_back(cyc);
         end
      end
      if (bus.rsp_valid) rv_cnt++;
      if (rst_n && bus.rsp_valid && rsp_rdy) begin
         last_res  = bus.rsp_result;
         last_zero = bus.rsp_zero;
         last_id   = bus.rsp_id;
      end
      for (int i = 0; i < N; i++) begin
         if (bus.req_ready[i]) begin
            if (keep_all) new_op(i);
            else pend[i] = 1'b0;
         end
      end
      cyc++;
   endtask

   task automatic run(int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset(logic [N-1:0] valid_during);
      pend    = valid_during;
      rst_drv = 1'b0;
      run(3);
      rst_drv = 1'b1;
      pend    = '0;
      grant_log.delete();
      grant_cyc.delete();
   endtask

   initial begin
      for (int i = 0; i < N; i++) begin
         ra[i] = '0; rb[i] = '0; rop[i] = '0;
      end

      // reset with every requester valid: outputs zero, no accept strobe
      do_reset('1);

      // ADD 0x05 + 0x03 from requester 0
      rsp_rdy = 1'b1;
      set_req(0, 8'h05, 8'h03, 3'd1);
      run(5);
      check("t2_id", last_id, 0);
      check("t2_result", last_res, 8'h08);
      check("t2_zero", last_zero, 0);
      check("t2_latency", grant_cyc.size() > 0 ? 1 : 0, 1);

      // SUB 0x10 - 0x10 then ADD 0xFF + 0x01 from requester 1
      set_req(1, 8'h10, 8'h10, 3'd2);
      run(5);
      check("t3_sub_result", last_res, 8'h00);
      check("t3_sub_zero", last_zero, 1);
      check("t3_sub_id", last_id, 1);
      set_req(1, 8'hFF, 8'h01, 3'd1);
      run(5);
      check("t3_wrap_result", last_res, 8'h00);
      check("t3_wrap_zero", last_zero, 1);

      // all four held valid: 0,1,2,3,0 with one accept every 3 cycles
      do_reset('0);
      keep_all = 1'b1;
      for (int i = 0; i < N; i++) new_op(i);
      run(14);
      keep_all = 1'b0;
      pend = '0;
      run(4);
      check("t4_grant_count", grant_log.size() >= 5 ? 1 : 0, 1);
      for (int i = 0; i < 5 && i < grant_log.size(); i++) begin
         check("t4_grant_order", grant_log[i], i % N);
         if (i > 0) check("t4_interval", grant_cyc[i] - grant_cyc[i-1], 3);
      end

      // response back-pressure for 5 cycles while another requester waits
      do_reset('0);
      rsp_rdy = 1'b0;
      set_req(2, 8'h21, 8'h12, 3'd4);
      rv_cnt = 0;
      run(2);
      set_req(3, 8'h01, 8'h01, 3'd1);
      run(5);
      rsp_rdy = 1'b1;
      run(1);
      check("t5_rsp_cycles", rv_cnt, 6);
      check("t5_grants_while_busy", grant_log.size(), 1);
      check("t5_result", last_res, 8'h33);
      run(5);
      check("t5_next_id", last_id, 3);

      // reset pulse during EXEC: that op never responds
      do_reset('0);
      set_req(0, 8'h11, 8'h22, 3'd1);
      run(1);
      rst_drv = 1'b0;
      run(1);
      rst_drv = 1'b1;
      rv_cnt = 0;
      run(6);
      check("t6_no_rsp", rv_cnt, 0);

`ifdef ARB_LOCK_EN
      // locked requester 2 wins twice in a row
      do_reset('0);
      keep_all = 1'b1;
      for (int i = 0; i < N; i++) new_op(i);
      rlock = 4'b0100;
      for (int s = 0; s < 16; s++) begin
         step();
         if (grant_log.size() >= 3) rlock = '0;
      end
      keep_all = 1'b0;
      pend = '0;
      run(4);
      check("lock_grant_count", grant_log.size() >= 5 ? 1 : 0, 1);
      if (grant_log.size() >= 5) begin
         check("lock_g0", grant_log[0], 0);
         check("lock_g1", grant_log[1], 1);
         check("lock_g2", grant_log[2], 2);
         check("lock_g3", grant_log[3], 2);
         check("lock_g4", grant_log[4], 3);
      end
`endif

      // randomized traffic with back-pressure, drops, lock bits and rare resets
      do_reset('0);
      n_rsp = 0;
      for (int s = 0; s < 800; s++) begin
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 3) == 0) new_op(i);
            else if (pend[i] && $urandom_range(0, 15) == 0) pend[i] = 1'b0;
         end
         rlock   = N'($urandom_range(0, (1 << N) - 1));
         rsp_rdy = ($urandom_range(0, 3) != 0);
         rst_drv = ($urandom_range(0, 199) != 0);
         step();
      end
      rst_drv = 1'b1;
      rsp_rdy = 1'b1;
      pend = '0;
      run(4);
      check("random_rsp_seen", n_rsp > 20 ? 1 : 0, 1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
